// File: rtl/lc3b_decode_stage_if.sv
// Fetch-to-decode handshake and the decode-to-execute control bundle of the
// LC-3b pipeline, grouped so the stage has a single bus port.
interface lc3b_decode_stage_if;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_aluop;
  logic        id_load_cc;
  logic        id_load_regfile;
  logic [2:0]  id_sr1;
  logic [2:0]  id_sr2;
  logic [2:0]  id_dest;
  logic [2:0]  id_nzp;
  logic [15:0] id_imm;
  logic        id_imm_sel;
  logic [15:0] id_pc;
  logic        id_illegal;

  // Pipeline side that feeds decode and consumes its output register
  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, id_valid, id_opcode, id_aluop, id_load_cc, id_load_regfile,
           id_sr1, id_sr2, id_dest, id_nzp, id_imm, id_imm_sel, id_pc, id_illegal
  );

  // The decode stage itself
  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, id_valid, id_opcode, id_aluop, id_load_cc, id_load_regfile,
           id_sr1, id_sr2, id_dest, id_nzp, id_imm, id_imm_sel, id_pc, id_illegal
  );
endinterface

// File: rtl/lc3b_decode_stage.sv
// LC-3b decode stage: decodes one instruction per cycle into a registered
// control bundle and holds back a consumer of a just-loaded register for one bubble.
module lc3b_decode_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  lc3b_decode_stage_if.slave bus
);

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SHF  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_AND  = 4'h1;
  localparam logic [3:0] ALU_NOT  = 4'h2;
  localparam logic [3:0] ALU_PASS = 4'h3;
  localparam logic [3:0] ALU_SLL  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_SRA  = 4'h6;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  aluop;
    logic        load_cc;
    logic        load_regfile;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dest;
    logic [2:0]  nzp;
    logic [15:0] imm;
    logic        imm_sel;
    logic        illegal;
  } ctrl_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  // Byte accesses use the raw offset; word accesses scale it by two
  function automatic logic [15:0] mem_offset(input logic [15:0] ir);
    logic [15:0] off;
    off = {{10{ir[5]}}, ir[5:0]};
    if ((ir[15:12] == OP_LDB) || (ir[15:12] == OP_STB)) begin
      return off;
    end else begin
      return {off[14:0], 1'b0};
    end
  endfunction

  function automatic ctrl_t decode(input logic [15:0] ir);
    ctrl_t c;
    c        = '0;
    c.opcode = ir[15:12];
    case (ir[15:12])
      OP_ADD, OP_AND: begin
        c.aluop        = (ir[15:12] == OP_AND) ? ALU_AND : ALU_ADD;
        c.dest         = ir[11:9];
        c.sr1          = ir[8:6];
        c.sr2          = ir[2:0];
        c.imm_sel      = ir[5];
        c.imm          = {{11{ir[4]}}, ir[4:0]};
        c.load_cc      = 1'b1;
        c.load_regfile = 1'b1;
      end
      OP_NOT: begin
        c.aluop        = ALU_NOT;
        c.dest         = ir[11:9];
        c.sr1          = ir[8:6];
        c.load_cc      = 1'b1;
        c.load_regfile = 1'b1;
      end
      OP_SHF: begin
        if (ir[5:4] == 2'b10) begin
          c.illegal = 1'b1;
        end else begin
          case (ir[5:4])
            2'b00:   c.aluop = ALU_SLL;
            2'b01:   c.aluop = ALU_SRL;
            default: c.aluop = ALU_SRA;
          endcase
          c.dest         = ir[11:9];
          c.sr1          = ir[8:6];
          c.imm          = {12'h000, ir[3:0]};
          c.imm_sel      = 1'b1;
          c.load_cc      = 1'b1;
          c.load_regfile = 1'b1;
        end
      end
      OP_LDB, OP_LDR, OP_LDI: begin
        c.aluop        = ALU_ADD;
        c.dest         = ir[11:9];
        c.sr1          = ir[8:6];
        c.imm          = mem_offset(ir);
        c.imm_sel      = 1'b1;
        c.load_cc      = 1'b1;
        c.load_regfile = 1'b1;
      end
      OP_STB, OP_STR, OP_STI: begin
        c.aluop   = ALU_ADD;
        c.sr1     = ir[8:6];
        c.sr2     = ir[11:9];
        c.imm     = mem_offset(ir);
        c.imm_sel = 1'b1;
      end
      OP_LEA: begin
        c.aluop        = ALU_PASS;
        c.dest         = ir[11:9];
        c.imm          = {{6{ir[8]}}, ir[8:0], 1'b0};
        c.load_regfile = 1'b1;
      end
      OP_BR: begin
        c.nzp = ir[11:9];
        c.imm = {{6{ir[8]}}, ir[8:0], 1'b0};
      end
      OP_JMP: begin
        c.sr1 = ir[8:6];
      end
      OP_JSR: begin
        c.dest         = 3'd7;
        c.load_regfile = 1'b1;
        if (ir[11]) begin
          c.imm = {{4{ir[10]}}, ir[10:0], 1'b0};
        end else begin
          c.sr1 = ir[8:6];
        end
      end
      OP_TRAP: begin
        c.dest         = 3'd7;
        c.load_regfile = 1'b1;
        c.imm          = {7'h00, ir[7:0], 1'b0};
      end
      OP_RTI: begin
        c.illegal = 1'b1;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Only register fields the incoming instruction actually consumes count
  function automatic logic reads_reg(input logic [15:0] ir, input logic [2:0] r);
    logic hit;
    hit = 1'b0;
    case (ir[15:12])
      OP_ADD, OP_AND:                           hit = (ir[8:6] == r) || (!ir[5] && (ir[2:0] == r));
      OP_NOT, OP_SHF, OP_LDB, OP_LDR, OP_LDI,
      OP_JMP:                                   hit = (ir[8:6] == r);
      OP_STB, OP_STR, OP_STI:                   hit = (ir[8:6] == r) || (ir[11:9] == r);
      OP_JSR:                                   hit = !ir[11] && (ir[8:6] == r);
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic  valid_r;
  ctrl_t ctrl_r;
  logic [15:0] pc_r;
  ctrl_t decoded_s;
  logic  advance_s;
  logic  hazard_s;
  logic  ready_s;
  logic  capture_s;

  assign decoded_s = decode(bus.if_instr);

  // Handshake and load-use interlock
  always_comb begin
    advance_s = 1'b0;
    hazard_s  = 1'b0;
    ready_s   = 1'b0;
    capture_s = 1'b0;
    advance_s = !valid_r || bus.ex_ready;
    hazard_s  = bus.if_valid && valid_r && is_load(ctrl_r.opcode) &&
                ctrl_r.load_regfile && reads_reg(bus.if_instr, ctrl_r.dest);
    ready_s   = advance_s && !hazard_s;
    capture_s = bus.if_valid && ready_s && !bus.flush;
  end

  // Output register: flush kills, capture loads, an advance with nothing taken drains
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      pc_r    <= RESET_PC;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
      ctrl_r  <= decoded_s;
      pc_r    <= bus.if_pc;
    end else if (advance_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign bus.if_ready        = ready_s;
  assign bus.id_valid        = valid_r;
  assign bus.id_opcode       = ctrl_r.opcode;
  assign bus.id_aluop        = ctrl_r.aluop;
  assign bus.id_load_cc      = ctrl_r.load_cc;
  assign bus.id_load_regfile = ctrl_r.load_regfile;
  assign bus.id_sr1          = ctrl_r.sr1;
  assign bus.id_sr2          = ctrl_r.sr2;
  assign bus.id_dest         = ctrl_r.dest;
  assign bus.id_nzp          = ctrl_r.nzp;
  assign bus.id_imm          = ctrl_r.imm;
  assign bus.id_imm_sel      = ctrl_r.imm_sel;
  assign bus.id_pc           = pc_r;
  assign bus.id_illegal      = ctrl_r.illegal;

endmodule
